mult_share_ctrl: RTL and testbench

//   Time-shares one array_multiplier_4bit between NUM_REQ requesters.

---
 rtl/mult_share_pkg.sv | 15 +
 rtl/array_multiplier_4bit.sv | 22 ++
 rtl/mult_share_ctrl_rr_arbiter.sv | 26 ++
 rtl/mult_share_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mult_share_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_pkg.sv
// Shared types and widths for the time-shared 4x4 multiplier controller.
package mult_share_pkg;

  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  // Controller phases: waiting for a request, letting the multiplier settle,
  // holding the response until the consumer takes it.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RSP  = 2'd2
  } state_e;

endpackage

// File: rtl/array_multiplier_4bit.sv
// Combinational 4x4 unsigned array multiplier (sum of shifted partial products).
module array_multiplier_4bit
  import mult_share_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  logic [PROD_W-1:0] acc;

  // Accumulate one AND-row per bit of b, shifted to its weight.
  always_comb begin
    acc = '0;
    for (int i = 0; i < OP_W; i++) begin
      acc = acc + ({{(PROD_W - OP_W){1'b0}}, (a & {OP_W{b[i]}})} << i);
    end
  end

  assign p = acc;

endmodule

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or above
// ptr, wrapping past the top index. Output is one-hot or all zero.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic [2*N-1:0] req_dbl;
  logic [2*N-1:0] gnt_dbl;
  logic [N-1:0]   req_rot;
  logic [N-1:0]   gnt_rot;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[N-1:0];
    gnt_rot = req_rot & (~req_rot + 1'b1);
    gnt_dbl = {{N{1'b0}}, gnt_rot} << ptr;
    grant   = gnt_dbl[N-1:0] | gnt_dbl[2*N-1:N];
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Time-shares one array_multiplier_4bit between NUM_REQ requesters.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Request side: req_ready is a combinational one-hot grant, only
// offered in IDLE, and the selected operands are captured on that edge.
// Response side: rsp_valid/rsp_id/rsp_p are registered and stay stable until
// the edge where rsp_ready is also high; rsp_p is only meaningful while
// rsp_valid is high.
//
// Operands are registered in front of the combinational multiplier and the
// product is registered behind it, so the multiplier gets MUL_CYCLES cycles to
// settle (a multicycle path between op_*_q and rsp_p_q).
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int MUL_CYCLES = 1,
  parameter  int CNT_W      = 16,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [OP_W*NUM_REQ-1:0]   req_a,
  input  logic [OP_W*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [PROD_W-1:0]         rsp_p,
  input  logic                      rsp_ready,
  output logic                      busy,
  output logic [CNT_W-1:0]          ops_count
);

  // Settle counter wide enough to hold MUL_CYCLES-1.
  localparam int            SW          = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(MUL_CYCLES - 1);

  state_e              state_q,     state_d;
  logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
  logic [SW-1:0]       settle_q,    settle_d;
  logic [OP_W-1:0]     op_a_q,      op_a_d;
  logic [OP_W-1:0]     op_b_q,      op_b_d;
  logic [ID_W-1:0]     op_id_q,     op_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
  logic [PROD_W-1:0]   rsp_p_q,     rsp_p_d;
  logic                busy_q,      busy_d;
  logic [CNT_W-1:0]    ops_count_q, ops_count_d;

  logic [NUM_REQ-1:0]  grant;
  logic                accept;
  logic [ID_W-1:0]     sel_id;
  logic [ID_W-1:0]     sel_next;
  logic [OP_W-1:0]     sel_a;
  logic [OP_W-1:0]     sel_b;
  logic [PROD_W-1:0]   mul_p;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  array_multiplier_4bit u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  // Grants are only offered while idle.
  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);

  // Decode the one-hot grant into id, next pointer and operand slice.
  always_comb begin
    sel_id   = '0;
    sel_next = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_id   = ID_W'(i);
        sel_next = ID_W'((i + 1) % NUM_REQ);
        sel_a    = req_a[OP_W*i +: OP_W];
        sel_b    = req_b[OP_W*i +: OP_W];
      end
    end
  end

  // Next-state and registered-output logic for the IDLE/MUL/RSP sequence.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    settle_d    = settle_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_p_d     = rsp_p_q;
    ops_count_d = ops_count_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          op_id_d  = sel_id;
          rr_ptr_d = sel_next;
          settle_d = SETTLE_LOAD;
          state_d  = MUL;
        end
      end
      MUL: begin
        if (settle_q == '0) begin
          rsp_p_d     = mul_p;
          rsp_id_d    = op_id_q;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (ops_count_q != '1) begin
            ops_count_d = ops_count_q + 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      settle_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_p_q     <= '0;
      busy_q      <= 1'b0;
      ops_count_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      settle_q    <= settle_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_p_q     <= rsp_p_d;
      busy_q      <= busy_d;
      ops_count_q <= ops_count_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign busy      = busy_q;
  assign ops_count = ops_count_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl: two instances (MUL_CYCLES=1/CNT_W=16 and
// MUL_CYCLES=3/CNT_W=3) share one set of inputs; each is tracked by a
// transaction-level model and compared every cycle, plus directed checks.
module tb_mult_share_ctrl;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic           rsp_ready;

  logic [N-1:0] rdy0, rdy1;
  logic         v0, v1;
  logic [1:0]   id0, id1;
  logic [7:0]   p0, p1;
  logic         b0, b1;
  logic [15:0]  c0;
  logic [2:0]   c1;

  mult_share_ctrl #(.NUM_REQ(N), .MUL_CYCLES(1), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(rdy0), .rsp_valid(v0), .rsp_id(id0), .rsp_p(p0), .rsp_ready(rsp_ready),
    .busy(b0), .ops_count(c0)
  );

  mult_share_ctrl #(.NUM_REQ(N), .MUL_CYCLES(3), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(rdy1), .rsp_valid(v1), .rsp_id(id1), .rsp_p(p1), .rsp_ready(rsp_ready),
    .busy(b1), .ops_count(c1)
  );

  // ---------------- reference model ----------------
  int mc[2]   = '{1, 3};
  int cmax[2] = '{65535, 7};
  bit m_fly[2];
  bit m_hold[2];
  int m_left[2], m_id[2], m_a[2], m_b[2], m_p[2], m_rid[2], m_ptr[2], m_ops[2];

  int n_total = 0;
  int n_bad   = 0;

  int e_id[5] = '{0, 1, 2, 3, 0};
  int e_p[5]  = '{14, 24, 36, 50, 14};

  function automatic int exp_grant(input int v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (((v >> idx) & 1) != 0) return 1 << idx;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_fly[k] = 0; m_hold[k] = 0; m_left[k] = 0; m_id[k] = 0; m_a[k] = 0;
      m_b[k] = 0; m_p[k] = 0; m_rid[k] = 0; m_ptr[k] = 0; m_ops[k] = 0;
    end
  endtask

  // Advance the model across the coming rising edge using current inputs.
  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (m_hold[k]) begin
        if (rsp_ready) begin
          m_hold[k] = 0;
          if (m_ops[k] < cmax[k]) m_ops[k]++;
        end
      end else if (m_fly[k]) begin
        m_left[k]--;
        if (m_left[k] == 0) begin
          m_fly[k]  = 0;
          m_hold[k] = 1;
          m_p[k]    = m_a[k] * m_b[k];
          m_rid[k]  = m_id[k];
        end
      end else begin
        int g;
        g = exp_grant(int'(req_valid), m_ptr[k]);
        for (int i = 0; i < N; i++) begin
          if (g == (1 << i)) begin
            m_fly[k]  = 1;
            m_left[k] = mc[k];
            m_id[k]   = i;
            m_a[k]    = int'((req_a >> (4 * i)) & 16'hF);
            m_b[k]    = int'((req_b >> (4 * i)) & 16'hF);
            m_ptr[k]  = (i + 1) % N;
          end
        end
      end
    end
  endtask

  task automatic cmp_inst(input int k, input int rdy, input int v, input int id,
                          input int p, input int bz, input int cnt);
    int busy_e;
    busy_e = (m_fly[k] || m_hold[k]) ? 1 : 0;
    chk($sformatf("u%0d req_ready", k), rdy, busy_e ? 0 : exp_grant(int'(req_valid), m_ptr[k]));
    chk($sformatf("u%0d rsp_valid", k), v, int'(m_hold[k]));
    chk($sformatf("u%0d rsp_id", k), id, m_rid[k]);
    chk($sformatf("u%0d rsp_p", k), p, m_p[k]);
    chk($sformatf("u%0d busy", k), bz, busy_e);
    chk($sformatf("u%0d ops_count", k), cnt, m_ops[k]);
  endtask

  // One clock: compare at the falling edge, then return just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (!rst_n) model_reset();
    cmp_inst(0, int'(rdy0), int'(v0), int'(id0), int'(p0), int'(b0), int'(c0));
    cmp_inst(1, int'(rdy1), int'(v1), int'(id1), int'(p1), int'(b1), int'(c1));
    if (rst_n) model_step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic put(input int i, input int a, input int b);
    req_a[4*i +: 4] = 4'(a);
    req_b[4*i +: 4] = 4'(b);
  endtask

  task automatic drain();
    int n;
    n = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while ((b0 || b1) && n < 20) begin
      tick();
      n++;
    end
    chk("drain idle", int'(b0 | b1), 0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Single op on requester i; pins latency and product on the 3-cycle instance.
  task automatic do_op(input int i, input int a, input int b);
    int lat;
    drain();
    put(i, a, b);
    req_valid = 4'(1 << i);
    rsp_ready = 1'b1;
    #1;
    chk("op grant u1", int'(rdy1), 1 << i);
    tick();
    req_valid = '0;
    lat = 0;
    while (!v1 && lat < 10) begin
      tick();
      lat++;
    end
    chk("u1 latency", lat, 3);
    chk("u1 product", int'(p1), a * b);
    chk("u1 id", int'(id1), i);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int got, n;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    tick();
    chk("reset rsp_valid", int'(v0), 0);
    chk("reset busy", int'(b0), 0);
    chk("reset ops_count", int'(c0), 0);
    chk("reset rsp_p", int'(p1), 0);
    rst_n = 1'b1;
    tick();

    // Single op on requester 0: 3*5.
    rsp_ready = 1'b1;
    put(0, 3, 5);
    req_valid = 4'b0001;
    #1;
    chk("t1 grant u0", int'(rdy0), 1);
    chk("t1 grant u1", int'(rdy1), 1);
    tick();
    req_valid = '0;
    chk("t1 mul rsp_valid", int'(v0), 0);
    chk("t1 mul busy", int'(b0), 1);
    tick();
    chk("t1 rsp_valid", int'(v0), 1);
    chk("t1 rsp_id", int'(id0), 0);
    chk("t1 rsp_p", int'(p0), 15);
    chk("t1 ops before hs", int'(c0), 0);
    tick();
    chk("t1 rsp_valid after hs", int'(v0), 0);
    chk("t1 ops_count", int'(c0), 1);
    drain();

    // All requesters valid: grant order 0,1,2,3,0.
    pulse_reset();
    for (int i = 0; i < N; i++) put(i, i + 2, i + 7);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    got = 0;
    n = 0;
    while (got < 5 && n < 60) begin
      tick();
      n++;
      if (v0) begin
        chk("t2 rsp_id", int'(id0), e_id[got]);
        chk("t2 rsp_p", int'(p0), e_p[got]);
        got++;
        if (got == 5) req_valid = '0;
      end
    end
    chk("t2 responses", got, 5);
    drain();

    // Response stall: outputs hold, no grants, no count change.
    put(2, 9, 7);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    n = 0;
    while (!v0 && n < 10) begin
      tick();
      n++;
    end
    chk("t3 rsp_valid", int'(v0), 1);
    req_valid = 4'hF;
    for (int s = 0; s < 5; s++) begin
      tick();
      chk("t3 hold valid", int'(v0), 1);
      chk("t3 hold id", int'(id0), 2);
      chk("t3 hold p", int'(p0), 63);
      chk("t3 no grant", int'(rdy0), 0);
      chk("t3 count held", int'(c0), 5);
    end
    rsp_ready = 1'b1;
    tick();
    req_valid = '0;
    chk("t3 valid after hs", int'(v0), 0);
    chk("t3 count after hs", int'(c0), 6);

    // Exhaustive operands via requester 2.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        do_op(2, a, b);
    drain();
    chk("t4 u0 ops_count", int'(c0), 262);
    chk("t4 u1 ops_count sat", int'(c1), 7);

    // Asynchronous reset while the 3-cycle instance is mid-multiply.
    put(2, 6, 6);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    chk("t5 u1 busy before rst", int'(b1), 1);
    rst_n = 1'b0;
    #1;
    chk("t5 u1 rsp_valid", int'(v1), 0);
    chk("t5 u1 busy", int'(b1), 0);
    chk("t5 u1 ops_count", int'(c1), 0);
    chk("t5 u0 busy", int'(b0), 0);
    chk("t5 u0 ops_count", int'(c0), 0);
    tick();
    rst_n = 1'b1;
    put(1, 1, 2);
    put(3, 3, 4);
    req_valid = 4'b1010;
    #1;
    chk("t5 u0 grant", int'(rdy0), 2);
    chk("t5 u1 grant", int'(rdy1), 2);
    tick();
    req_valid = '0;
    drain();

    // Saturation of the 3-bit counter.
    for (int k = 0; k < 9; k++) do_op(k % N, $urandom_range(0, 15), $urandom_range(0, 15));
    drain();
    chk("t6 u1 ops_count", int'(c1), 7);
    chk("t6 u0 ops_count", int'(c0), 10);

    // Random traffic with occasional resets.
    for (int c = 0; c < 2000; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      req_a     = 16'($urandom);
      req_b     = 16'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
    end
    rst_n = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
